// File: rtl/hpdmc_busif_mp.sv
// hpdmc_busif_mp: arbitrates several FML masters onto one HPDMC mgmt/data-ack pair.
// Define HPDMC_BUSIF_ROUNDROBIN_EN for round-robin; otherwise lowest port index wins.
module hpdmc_busif_mp #(
    parameter int sdram_depth = 26,
    parameter int nports      = 2
) (
    input  logic                          sys_clk,
    input  logic                          sdram_rst,
    input  logic [nports*sdram_depth-1:0] fml_adr,
    input  logic [nports-1:0]             fml_stb,
    input  logic [nports-1:0]             fml_we,
    output logic [nports-1:0]             fml_ack,
    output logic                          mgmt_stb,
    output logic                          mgmt_we,
    output logic [sdram_depth-2:0]        mgmt_address,
    input  logic                          mgmt_ack,
    input  logic                          data_ack,
    output logic                          busy
);
    localparam int GW = (nports > 1) ? $clog2(nports) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [GW-1:0]          r_g;
    logic [GW-1:0]          w_gnt;
    logic                   r_stb;
    logic                   r_we;
    logic [sdram_depth-2:0] r_adr;
    logic [sdram_depth-2:0] w_adr;
    logic                   w_we;
    logic                   w_req;
    logic                   w_done;
    logic                   w_unused;

    assign w_req = |fml_stb;

`ifdef HPDMC_BUSIF_ROUNDROBIN_EN
    logic [GW-1:0] r_last;
    int            w_rank;
    int            w_best;

    // rank = distance after the last winner; smallest requesting rank wins
    always_comb begin
        w_gnt  = '0;
        w_best = nports;
        w_rank = 0;
        for (int j = 0; j < nports; j++) begin
            if (j > int'(r_last))
                w_rank = j - int'(r_last) - 1;
            else
                w_rank = j - int'(r_last) - 1 + nports;
            if (fml_stb[j] && (w_rank < w_best)) begin
                w_best = w_rank;
                w_gnt  = GW'(j);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sdram_rst)
            r_last <= GW'(nports - 1);
        else if ((r_state == IDLE) && w_req)
            r_last <= w_gnt;
    end
`else
    always_comb begin
        w_gnt = '0;
        for (int j = nports - 1; j >= 0; j--) begin
            if (fml_stb[j])
                w_gnt = GW'(j);
        end
    end
`endif

    always_comb begin
        w_adr = '0;
        w_we  = 1'b0;
        for (int j = 0; j < nports; j++) begin
            if (w_gnt == GW'(j)) begin
                w_adr = fml_adr[j*sdram_depth+1 +: sdram_depth-1];
                w_we  = fml_we[j];
            end
        end
    end

    // byte-lane bit 0 of each address is not forwarded
    always_comb begin
        w_unused = 1'b0;
        for (int j = 0; j < nports; j++)
            w_unused = w_unused ^ fml_adr[j*sdram_depth];
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req)
                    w_next = ISSUE;
            end
            ISSUE: begin
                if (mgmt_ack) begin
                    w_next = data_ack ? IDLE : WAIT_DATA;
                    w_done = data_ack;
                end
            end
            WAIT_DATA: begin
                if (data_ack) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        fml_ack = '0;
        for (int j = 0; j < nports; j++)
            fml_ack[j] = w_done && !sdram_rst && (r_g == GW'(j));
    end

    always_ff @(posedge sys_clk) begin
        if (sdram_rst) begin
            r_state <= IDLE;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_g     <= '0;
        end else begin
            r_state <= w_next;
            r_stb   <= (w_next == ISSUE);
            if ((r_state == IDLE) && w_req) begin
                r_g   <= w_gnt;
                r_we  <= w_we;
                r_adr <= w_adr;
            end
        end
    end

    assign mgmt_stb     = r_stb;
    assign mgmt_we      = r_we;
    assign mgmt_address = r_adr;
    assign busy         = (r_state != IDLE);

endmodule
